// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding, default bus addresses and
// the sprite-table transfer length.
// Optional feature macro: OAM_DMA_ALIGN_EN adds the ALIGN state.
package nes_pkg;

    // Default CPU write address that starts a sprite DMA.
    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    // Default PPU OAM data port written by the copy engine.
    localparam logic [15:0] PPU_OAM_ADDR  = 16'h2004;
    // One full OAM page is copied per transfer.
    localparam int          OAM_XFER_LEN  = 256;
    // Final byte index of a transfer.
    localparam logic [7:0]  OAM_LAST_CNT  = 8'(OAM_XFER_LEN - 1);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_READ,
        ST_WRITE
    } dma_state_t;
`endif

endpackage

// File: rtl/dma_bus_mux.sv
// System bus multiplexer: hands the bus to the CPU while the DMA engine is
// idle and to the copy engine otherwise. Purely combinational.
// Optional feature macro: OAM_DMA_ALIGN_EN adds the ALIGN state.
module dma_bus_mux
    import nes_pkg::*;
#(
    parameter logic [15:0] OAM_ADDR = PPU_OAM_ADDR
) (
    input  dma_state_t  state,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  page,
    input  logic [7:0]  cnt,
    input  logic [7:0]  data_latch,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we
);

    // Select bus owner and drive address/data/strobe for the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bus_addr = cpu_addr;
        bus_dout = data_latch;
        bus_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                bus_dout = cpu_dout;
                bus_we   = cpu_we;
            end
            ST_HALT: begin
                bus_addr = cpu_addr;
            end
`ifdef OAM_DMA_ALIGN_EN
            ST_ALIGN: begin
                bus_addr = cpu_addr;
            end
`endif
            ST_READ: begin
                bus_addr = {page, cnt};
            end
            ST_WRITE: begin
                bus_addr = OAM_ADDR;
                bus_we   = 1'b1;
            end
            default: begin
                bus_addr = cpu_addr;
            end
        endcase
    end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to TRIG_ADDR stalls the CPU and copies the
// 256-byte page {page,00}..{page,FF} into the PPU OAM data port, one
// read/write pair per byte.
// Optional feature macro: OAM_DMA_ALIGN_EN inserts one ALIGN cycle when the
// free-running parity flop is odd in HALT (513 or 514 stall cycles); without
// it the stall is always 513 cycles.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = DMA_TRIG_ADDR,
    parameter logic [15:0] OAM_ADDR  = PPU_OAM_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  bus_din,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        dma_busy
);

    dma_state_t  state;
    dma_state_t  state_nxt;
    logic [7:0]  page;
    logic [7:0]  cnt;
    logic [7:0]  data_latch;
    logic        trigger;

    // Only an idle engine can be started; writes while stalled are ignored.
    assign trigger = (state == ST_IDLE) && cpu_we && (cpu_addr == TRIG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    // Free-running cycle parity, independent of the DMA state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity <= 1'b0;
        else      parity <= ~parity;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (trigger) state_nxt = ST_HALT;
            end
            ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_nxt = parity ? ST_ALIGN : ST_READ;
`else
                state_nxt = ST_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ST_ALIGN: begin
                state_nxt = ST_READ;
            end
`endif
            ST_READ: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                state_nxt = (cnt == OAM_LAST_CNT) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Source page, byte counter and data latch.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the one-byte data latch is a plain register, so it is reset
        // with the rest of the datapath.
        if (!rst) begin
            page       <= 8'h00;
            cnt        <= 8'h00;
            data_latch <= 8'h00;
        end else begin
            if (trigger) begin
                page <= cpu_dout;
                cnt  <= 8'h00;
            end
            if (state == ST_READ) begin
                data_latch <= bus_din;
            end
            if (state == ST_WRITE) begin
                // Wraps within the page; the page itself never carries.
                cnt <= cnt + 8'h01;
            end
        end
    end

    // Handshake outputs decoded straight from registered state.
    assign cpu_rdy  = (state == ST_IDLE);
    assign dma_busy = (state != ST_IDLE);

    dma_bus_mux #(
        .OAM_ADDR (OAM_ADDR)
    ) u_bus_mux (
        .state      (state),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_we     (cpu_we),
        .page       (page),
        .cnt        (cnt),
        .data_latch (data_latch),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_we     (bus_we)
    );

endmodule
